// File: rtl/spi_pkg.sv
// Shared types and constants for the single-byte SPI master.
package spi_pkg;

  localparam int unsigned DATA_W = 8;
  localparam logic        RW_WRITE = 1'b0;
  localparam logic        RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period divider with registered SCK level and rise/fall/tick strobes.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cnt_en_i,
  input  logic sck_en_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o,
  output logic sck_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic          sck_q, sck_d;

  // tick marks the last cycle of a half-period; SCK only toggles when sck_en_i allows it
  assign tick_o = cnt_en_i && (div_q == CW'(CLK_DIV - 1));
  assign rise_o = tick_o && sck_en_i && !sck_q;
  assign fall_o = tick_o && sck_en_i && sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    div_d = div_q + CW'(1);
    sck_d = sck_q;
    if (!cnt_en_i || tick_o) begin
      div_d = '0;
    end
    if (tick_o && sck_en_i) begin
      sck_d = ~sck_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 single-byte SPI master: request/ready handshake, 8-bit full-duplex shift.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rw_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] spi_tx_data_i,
  input  logic              spi_miso_i,
  output logic              spi_mosi_o,
  output logic              spi_clk_o,
  output logic              spi_ss_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] spi_rx_data_o
);

  localparam int unsigned BIT_W = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_out_q, rx_out_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              idle_q, idle_d;
  logic              tick, rise, fall;
  logic              cnt_en, sck_en;

  // SETUP is the first SCK-low half-period, so the divider already runs there
  assign cnt_en = (state_q != IDLE);
  assign sck_en = (state_q == SETUP) || (state_q == SHIFT);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .cnt_en_i(cnt_en),
    .sck_en_i(sck_en),
    .tick_o  (tick),
    .rise_o  (rise),
    .fall_o  (fall),
    .sck_o   (spi_clk_o)
  );

  assign spi_mosi_o    = tx_q[DATA_W-1];
  assign spi_ss_o      = idle_q;
  assign ready_o       = idle_q;
  assign spi_rx_data_o = rx_out_q;

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rx_out_d = rx_out_q;
    bit_d    = bit_q;
    idle_d   = idle_q;
    if (rise) begin
      rx_d = {rx_q[DATA_W-2:0], spi_miso_i};
    end
    unique case (state_q)
      IDLE: begin
        if (ready_i) begin
          state_d = SETUP;
          tx_d    = (rw_i == RW_READ) ? '0 : spi_tx_data_i;
          bit_d   = '0;
          idle_d  = 1'b0;
        end
      end
      SETUP: begin
        if (rise) state_d = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = HOLD;
          end else begin
            tx_d  = {tx_q[DATA_W-2:0], 1'b0};
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d  = IDLE;
          rx_out_d = rx_q;
          tx_d     = '0;
          idle_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      tx_q     <= '0;
      rx_out_q <= '0;
      bit_q    <= '0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_out_q <= rx_out_d;
      bit_q    <= bit_d;
      idle_q   <= idle_d;
    end
  end

  // rx shift register is fully rewritten by every transfer, so it needs no reset
  always_ff @(posedge clk_i) begin
    rx_q <= rx_d;
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master (CLK_DIV=2 and CLK_DIV=1 instances) against a timing/byte model.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready_drv, rw_drv, miso_drv, sel;
  logic [7:0] tx_drv;

  logic       rdy_in0, rdy_in1;
  logic       mosi0, sck0, ss0, rdy0;
  logic       mosi1, sck1, ss1, rdy1;
  logic [7:0] rx0, rx1;

  logic       mon_mosi, mon_sck, mon_ss, mon_ready;
  logic [7:0] mon_rx;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  assign rdy_in0   = ready_drv && !sel;
  assign rdy_in1   = ready_drv && sel;
  assign mon_mosi  = sel ? mosi1 : mosi0;
  assign mon_sck   = sel ? sck1  : sck0;
  assign mon_ss    = sel ? ss1   : ss0;
  assign mon_ready = sel ? rdy1  : rdy0;
  assign mon_rx    = sel ? rx1   : rx0;

  spi_master #(.CLK_DIV(2)) dut (
    .clk_i(clk), .rst_i(rst), .rw_i(rw_drv), .ready_i(rdy_in0),
    .spi_tx_data_i(tx_drv), .spi_miso_i(miso_drv), .spi_mosi_o(mosi0),
    .spi_clk_o(sck0), .spi_ss_o(ss0), .ready_o(rdy0), .spi_rx_data_o(rx0)
  );

  spi_master #(.CLK_DIV(1)) dut_div1 (
    .clk_i(clk), .rst_i(rst), .rw_i(rw_drv), .ready_i(rdy_in1),
    .spi_tx_data_i(tx_drv), .spi_miso_i(miso_drv), .spi_mosi_o(mosi1),
    .spi_clk_o(sck1), .spi_ss_o(ss1), .ready_o(rdy1), .spi_rx_data_o(rx1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_mosi(input logic [7:0] tx, input logic rw);
    return rw ? 8'h00 : tx;
  endfunction

  // Request a transfer; returns at E0+#1 after checking the start state.
  task automatic start(input logic [7:0] tx, input logic rw, input logic [7:0] mb, input bit keep);
    logic [7:0] em;
    em = model_mosi(tx, rw);
    @(negedge clk);
    tx_drv = tx; rw_drv = rw; miso_drv = mb[7]; ready_drv = 1'b1;
    @(posedge clk); #1;
    if (!keep) ready_drv = 1'b0;
    check("start_ss", 32'(mon_ss), 32'(0));
    check("start_ready", 32'(mon_ready), 32'(0));
    check("start_mosi", 32'(mon_mosi), 32'(em[7]));
  endtask

  // Acts as the slave and checks SCK timing, MOSI bits, completion time and rx byte.
  task automatic watch(input logic [7:0] em, input logic [7:0] mb, input int chg_at, input int stop_at);
    int d, kr, kf, ss_bad;
    bit prev, done;
    d = sel ? 1 : 2;
    kr = 0; kf = 0; ss_bad = 0; prev = 1'b0; done = 1'b0;
    for (int n = 1; n <= 17 * d + 4; n++) begin
      @(posedge clk); #1;
      if (n == chg_at) tx_drv = ~tx_drv;
      if (mon_sck && !prev) begin
        check("rise_time", 32'(n), 32'((2 * kr + 1) * d));
        if (kr < 8) check("mosi_bit", 32'(mon_mosi), 32'(em[7-kr]));
        kr++;
      end
      if (!mon_sck && prev) begin
        check("fall_time", 32'(n), 32'((2 * kf + 2) * d));
        kf++;
        if (kf < 8) miso_drv = mb[7-kf];
      end
      prev = mon_sck;
      if (n == stop_at) return;
      if (mon_ready) begin
        check("done_time", 32'(n), 32'(17 * d));
        check("sck_rises", 32'(kr), 32'(8));
        check("sck_falls", 32'(kf), 32'(8));
        check("rx_data", 32'(mon_rx), 32'(mb));
        check("done_ss", 32'(mon_ss), 32'(1));
        check("done_mosi", 32'(mon_mosi), 32'(0));
        check("ss_low_during", 32'(ss_bad), 32'(0));
        done = 1'b1;
        break;
      end
      if (mon_ss) ss_bad++;
    end
    if (!done && stop_at == 0) check("timeout", 32'(0), 32'(1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ss"}, 32'(mon_ss), 32'(1));
    check({tag, "_sck"}, 32'(mon_sck), 32'(0));
    check({tag, "_mosi"}, 32'(mon_mosi), 32'(0));
    check({tag, "_ready"}, 32'(mon_ready), 32'(1));
    check({tag, "_rx"}, 32'(mon_rx), 32'(0));
  endtask

  initial begin
    logic [7:0] tx, mb, a;
    logic       rw;
    int         sck_hi;
    rst = 1'b1; ready_drv = 1'b0; rw_drv = 1'b0; miso_drv = 1'b0; tx_drv = 8'h00; sel = 1'b0;

    sck_hi = 0;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (sck0 || sck1) sck_hi++;
    end
    rst = 1'b0;
    check("reset_sck_quiet", 32'(sck_hi), 32'(0));
    sel = 1'b0; check_idle("reset_div2");
    sel = 1'b1; check_idle("reset_div1");
    sel = 1'b0;

    start(8'h69, 1'b0, 8'hFF, 1'b0);
    watch(model_mosi(8'h69, 1'b0), 8'hFF, 0, 0);

    start(8'hC3, 1'b1, 8'hA5, 1'b0);
    watch(model_mosi(8'hC3, 1'b1), 8'hA5, 0, 0);

    for (int i = 0; i < 6; i++) begin
      tx = 8'($urandom); mb = 8'($urandom); rw = 1'($urandom_range(0, 1));
      start(tx, rw, mb, 1'b0);
      watch(model_mosi(tx, rw), mb, 0, 0);
    end

    // back-to-back with ready held high; tx changes mid-transfer
    a = 8'($urandom);
    start(a, 1'b0, 8'h3C, 1'b1);
    watch(a, 8'h3C, 10, 0);
    miso_drv = 1'b0;
    @(posedge clk); #1;
    ready_drv = 1'b0;
    check("b2b_start_ss", 32'(mon_ss), 32'(0));
    check("b2b_start_ready", 32'(mon_ready), 32'(0));
    watch(~a, 8'h5A, 0, 0);

    // reset after the 4th SCK rise
    start(8'hF0, 1'b0, 8'h81, 1'b0);
    watch(8'hF0, 8'h81, 0, 14);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("midreset");
    start(8'h96, 1'b0, 8'h17, 1'b0);
    watch(8'h96, 8'h17, 0, 0);

    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx = 8'($urandom); mb = 8'($urandom); rw = 1'($urandom_range(0, 1));
      start(tx, rw, mb, 1'b0);
      watch(model_mosi(tx, rw), mb, 0, 0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
